// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-requester VRAM port arbiter (display fetch vs CPU) with burst fairness and ack timeout
module vram_arbiter #(
    parameter int VGA_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        vga_access,
    input  logic [15:0] vga_address,
    output logic        vga_ack,
    output logic [15:0] vga_data,

    input  logic        cpu_access,
    input  logic [15:0] cpu_address,
    input  logic        cpu_wr_en,
    input  logic [15:0] cpu_wr_data,
    input  logic [1:0]  cpu_bytesel,
    output logic        cpu_ack,
    output logic [15:0] cpu_data,

    output logic        mem_access,
    output logic [15:0] mem_address,
    output logic        mem_wr_en,
    output logic [15:0] mem_wr_data,
    output logic [1:0]  mem_bytesel,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,

    output logic        timeout_err
);

    localparam int RUN_W  = $clog2(VGA_BURST + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(VGA_BURST);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VGA_BUSY = 2'd1,
        CPU_BUSY = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [RUN_W-1:0]  vga_run;
    logic [WAIT_W-1:0] wait_cnt;

    logic busy;
    logic vga_wins;
    logic grant_vga;
    logic grant_cpu;
    logic done_ok;
    logic done_tmo;
    logic finish_vga;
    logic finish_cpu;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_vga) begin
                    state_next = VGA_BUSY;
                end else if (grant_cpu) begin
                    state_next = CPU_BUSY;
                end
            end
            VGA_BUSY, CPU_BUSY: begin
                if (done_ok || done_tmo) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // VGA keeps priority until it has taken VGA_BURST grants in a row against a waiting CPU.
    always_comb begin
        busy       = (state == VGA_BUSY) || (state == CPU_BUSY);
        vga_wins   = vga_access && (!cpu_access || (vga_run != RUN_MAX));
        grant_vga  = (state == IDLE) && vga_wins;
        grant_cpu  = (state == IDLE) && !vga_wins && cpu_access;
        done_ok    = busy && mem_ack;
        done_tmo   = busy && !mem_ack && (wait_cnt == WAIT_LAST);
        finish_vga = (state == VGA_BUSY) && (done_ok || done_tmo);
        finish_cpu = (state == CPU_BUSY) && (done_ok || done_tmo);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_run     <= '0;
            wait_cnt    <= '0;
            mem_access  <= 1'b0;
            mem_address <= 16'h0000;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 16'h0000;
            mem_bytesel <= 2'b00;
            vga_ack     <= 1'b0;
            vga_data    <= 16'h0000;
            cpu_ack     <= 1'b0;
            cpu_data    <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            vga_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            timeout_err <= 1'b0;

            if (grant_vga) begin
                mem_access  <= 1'b1;
                mem_address <= vga_address;
                mem_wr_en   <= 1'b0;
                mem_wr_data <= 16'h0000;
                mem_bytesel <= 2'b11;
                wait_cnt    <= '0;
                if (!cpu_access) begin
                    vga_run <= '0;
                end else if (vga_run != RUN_MAX) begin
                    vga_run <= vga_run + RUN_W'(1);
                end
            end

            if (grant_cpu) begin
                mem_access  <= 1'b1;
                mem_address <= cpu_address;
                mem_wr_en   <= cpu_wr_en;
                mem_wr_data <= cpu_wr_data;
                mem_bytesel <= cpu_bytesel;
                wait_cnt    <= '0;
                vga_run     <= '0;
            end

            if (busy) begin
                if (done_ok || done_tmo) begin
                    mem_access  <= 1'b0;
                    timeout_err <= done_tmo;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end

            // An abandoned grant still completes towards the requester, with all-ones data.
            if (finish_vga) begin
                vga_ack  <= 1'b1;
                vga_data <= done_ok ? mem_data : 16'hFFFF;
            end

            if (finish_cpu) begin
                cpu_ack  <= 1'b1;
                cpu_data <= done_ok ? mem_data : 16'hFFFF;
            end
        end
    end

endmodule
